// File: rtl/alu_pkg.sv
// Shared definitions for the two-requester ALU arbiter: opcodes, FSM states,
// default operand width and the round-robin winner selection.
package alu_pkg;

  localparam int WIDTH_DEFAULT = 4;

  typedef enum logic [1:0] {
    OP_AND = 2'b00,
    OP_OR  = 2'b01,
    OP_ADD = 2'b10,
    OP_SUB = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  // On a tie the requester that was not served last wins.
  function automatic logic pick_winner(input logic req0, input logic req1,
                                       input logic last_served);
    logic win;
    if (req0 && req1) begin
      win = ~last_served;
    end else if (req1) begin
      win = 1'b1;
    end else begin
      win = 1'b0;
    end
    return win;
  endfunction

endpackage

// File: rtl/alu_arbiter_4_if.sv
// Request/operand/result bundle between the two requesters and the arbiter.
interface alu_arbiter_4_if
  import alu_pkg::*;
#(parameter int WIDTH = WIDTH_DEFAULT) ();

  logic             req0;
  logic [1:0]       op0;
  logic [WIDTH-1:0] a0;
  logic [WIDTH-1:0] b0;
  logic             req1;
  logic [1:0]       op1;
  logic [WIDTH-1:0] a1;
  logic [WIDTH-1:0] b1;
  logic [1:0]       gnt;
  logic [1:0]       done;
  logic [WIDTH-1:0] y;
  logic             cout;
  logic             zero;
  logic             busy;

  modport slave (
    input  req0, op0, a0, b0, req1, op1, a1, b1,
    output gnt, done, y, cout, zero, busy
  );

  modport master (
    output req0, op0, a0, b0, req1, op1, a1, b1,
    input  gnt, done, y, cout, zero, busy
  );

endinterface

// File: rtl/alu_4.sv
// Combinational ALU: AND/OR/ADD/SUB; cout is carry for ADD, no-borrow for SUB.
module alu_4
  import alu_pkg::*;
#(parameter int WIDTH = WIDTH_DEFAULT) (
  input  op_e              i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_y,
  output logic             o_cout
);

  logic [WIDTH:0] w_sum;
  logic [WIDTH:0] w_diff;

  assign w_sum  = {1'b0, i_a} + {1'b0, i_b};
  assign w_diff = {1'b0, i_a} - {1'b0, i_b};

  // Opcode decode; the MSB of the widened difference is the borrow.
  always_comb begin
    o_y    = {WIDTH{1'b0}};
    o_cout = 1'b0;
    case (i_op)
      OP_AND: begin
        o_y    = i_a & i_b;
        o_cout = 1'b0;
      end
      OP_OR: begin
        o_y    = i_a | i_b;
        o_cout = 1'b0;
      end
      OP_ADD: begin
        o_y    = w_sum[WIDTH-1:0];
        o_cout = w_sum[WIDTH];
      end
      OP_SUB: begin
        o_y    = w_diff[WIDTH-1:0];
        o_cout = ~w_diff[WIDTH];
      end
      default: begin
        o_y    = {WIDTH{1'b0}};
        o_cout = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/alu_arbiter_4.sv
// Two-requester round-robin arbiter in front of one shared ALU.
// One operation per IDLE -> EXEC -> DONE pass; all outputs are registered.
module alu_arbiter_4
  import alu_pkg::*;
#(parameter int WIDTH = WIDTH_DEFAULT) (
  input  logic          clk,
  input  logic          rst,
  alu_arbiter_4_if.slave bus
);

  state_e           r_state;
  logic             r_last;
  logic             r_win;
  op_e              r_op;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [1:0]       r_gnt;
  logic [1:0]       r_done;
  logic [WIDTH-1:0] r_y;
  logic             r_cout;
  logic             r_zero;
  logic             r_busy;

  state_e           w_state_nxt;
  logic             w_win_nxt;
  logic             w_last_nxt;
  logic             w_capture;
  logic             w_load;
  logic [1:0]       w_gnt_nxt;
  logic [1:0]       w_done_nxt;
  logic             w_busy_nxt;
  op_e              w_op_sel;
  logic [WIDTH-1:0] w_a_sel;
  logic [WIDTH-1:0] w_b_sel;
  logic [WIDTH-1:0] w_alu_y;
  logic             w_alu_cout;
  logic             w_alu_zero;

  alu_4 #(.WIDTH(WIDTH)) u_alu (
    .i_op   (r_op),
    .i_a    (r_a),
    .i_b    (r_b),
    .o_y    (w_alu_y),
    .o_cout (w_alu_cout)
  );

  assign w_alu_zero = (w_alu_y == {WIDTH{1'b0}});

  // Next-state, pulse and capture-select logic.
  always_comb begin
    w_state_nxt = r_state;
    w_win_nxt   = r_win;
    w_last_nxt  = r_last;
    w_capture   = 1'b0;
    w_load      = 1'b0;
    w_gnt_nxt   = 2'b00;
    w_done_nxt  = 2'b00;
    case (r_state)
      ST_IDLE: begin
        if (bus.req0 || bus.req1) begin
          w_win_nxt   = pick_winner(bus.req0, bus.req1, r_last);
          w_capture   = 1'b1;
          w_gnt_nxt   = w_win_nxt ? 2'b10 : 2'b01;
          w_state_nxt = ST_EXEC;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_EXEC: begin
        w_load      = 1'b1;
        w_done_nxt  = r_win ? 2'b10 : 2'b01;
        w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        w_last_nxt  = r_win;
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
    w_busy_nxt = (w_state_nxt != ST_IDLE);

    if (w_win_nxt) begin
      w_op_sel = op_e'(bus.op1);
      w_a_sel  = bus.a1;
      w_b_sel  = bus.b1;
    end else begin
      w_op_sel = op_e'(bus.op0);
      w_a_sel  = bus.a0;
      w_b_sel  = bus.b0;
    end
  end

  // State, capture and result registers; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_last  <= 1'b1;
      r_win   <= 1'b0;
      r_op    <= OP_AND;
      r_a     <= {WIDTH{1'b0}};
      r_b     <= {WIDTH{1'b0}};
      r_gnt   <= 2'b00;
      r_done  <= 2'b00;
      r_y     <= {WIDTH{1'b0}};
      r_cout  <= 1'b0;
      r_zero  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_last  <= w_last_nxt;
      r_win   <= w_win_nxt;
      r_gnt   <= w_gnt_nxt;
      r_done  <= w_done_nxt;
      r_busy  <= w_busy_nxt;
      if (w_capture) begin
        r_op <= w_op_sel;
        r_a  <= w_a_sel;
        r_b  <= w_b_sel;
      end
      if (w_load) begin
        r_y    <= w_alu_y;
        r_cout <= w_alu_cout;
        r_zero <= w_alu_zero;
      end
    end
  end

  assign bus.gnt  = r_gnt;
  assign bus.done = r_done;
  assign bus.y    = r_y;
  assign bus.cout = r_cout;
  assign bus.zero = r_zero;
  assign bus.busy = r_busy;

endmodule

// File: tb/tb_alu_arbiter_4.sv
// Scoreboard bench for alu_arbiter_4: directed requests push expected grants
// and results; a negedge monitor pops and compares whenever gnt/done pulse.
module tb_alu_arbiter_4;

  typedef struct packed {
    logic [1:0] done;
    logic [3:0] y;
    logic       cout;
    logic       zero;
  } res_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   cyc;
  int   gnt_cyc;
  logic [1:0] gq[$];
  res_t       rq[$];
  logic       hold_pending;
  res_t       hold_exp;

  alu_arbiter_4_if #(.WIDTH(4)) bus ();

  alu_arbiter_4 #(.WIDTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops expectations whenever the DUT pulses gnt or done.
  always @(negedge clk) begin
    if (rst) begin
      hold_pending = 1'b0;
    end else begin
      cyc++;
      if (hold_pending) begin
        chk("hold_y", {4'h0, bus.y}, {4'h0, hold_exp.y});
        chk("hold_cout", {7'h0, bus.cout}, {7'h0, hold_exp.cout});
        hold_pending = 1'b0;
      end
      if (bus.gnt != 2'b00) begin
        if (gq.size() == 0) begin
          chk("gnt_unexpected", {6'h0, bus.gnt}, 8'h00);
        end else begin
          chk("gnt", {6'h0, bus.gnt}, {6'h0, gq.pop_front()});
        end
        gnt_cyc = cyc;
      end
      if (bus.done != 2'b00) begin
        if (rq.size() == 0) begin
          chk("done_unexpected", {6'h0, bus.done}, 8'h00);
        end else begin
          res_t e;
          e = rq.pop_front();
          chk("done", {6'h0, bus.done}, {6'h0, e.done});
          chk("y", {4'h0, bus.y}, {4'h0, e.y});
          chk("cout", {7'h0, bus.cout}, {7'h0, e.cout});
          chk("zero", {7'h0, bus.zero}, {7'h0, e.zero});
          hold_exp     = e;
          hold_pending = 1'b1;
        end
        chk("done_latency", 8'(cyc - gnt_cyc), 8'd1);
      end
    end
  end

  // Raise a request, wait (bounded) for its grant, drop it in the grant cycle.
  task automatic do_req(input int who, input logic [1:0] op,
                        input logic [3:0] a, input logic [3:0] b);
    logic got;
    got = 1'b0;
    @(posedge clk);
    #1;
    if (who == 0) begin
      bus.req0 = 1'b1; bus.op0 = op; bus.a0 = a; bus.b0 = b;
    end else begin
      bus.req1 = 1'b1; bus.op1 = op; bus.a1 = a; bus.b1 = b;
    end
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (bus.gnt[who]) begin
        got = 1'b1;
        break;
      end
    end
    #1;
    if (who == 0) bus.req0 = 1'b0;
    else          bus.req1 = 1'b0;
    if (!got) chk("gnt_timeout", 8'h00, 8'h01);
  endtask

  task automatic wait_idle();
    logic ok;
    ok = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      #1;
      if (!bus.busy && gq.size() == 0 && rq.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("idle_timeout", 8'h00, 8'h01);
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_y"},    {4'h0, bus.y}, 8'h00);
    chk({tag, "_cout"}, {7'h0, bus.cout}, 8'h00);
    chk({tag, "_zero"}, {7'h0, bus.zero}, 8'h00);
    chk({tag, "_gnt"},  {6'h0, bus.gnt}, 8'h00);
    chk({tag, "_done"}, {6'h0, bus.done}, 8'h00);
    chk({tag, "_busy"}, {7'h0, bus.busy}, 8'h00);
  endtask

  initial begin
    checks = 0; errors = 0; cyc = 0; gnt_cyc = 0; hold_pending = 1'b0;
    rst = 1'b1;
    bus.req0 = 1'b0; bus.op0 = 2'b00; bus.a0 = 4'h0; bus.b0 = 4'h0;
    bus.req1 = 1'b0; bus.op1 = 2'b00; bus.a1 = 4'h0; bus.b1 = 4'h0;

    repeat (2) @(negedge clk);
    check_reset_outputs("rst");
    @(posedge clk);
    #1 rst = 1'b0;

    // Single request: ADD 0111 + 1010
    gq.push_back(2'b01);
    rq.push_back('{done: 2'b01, y: 4'b0001, cout: 1'b1, zero: 1'b0});
    do_req(0, 2'b10, 4'b0111, 4'b1010);
    wait_idle();

    // Contention straight after reset: requester 0 wins the first tie
    pulse_reset();
    gq.push_back(2'b01);
    gq.push_back(2'b10);
    rq.push_back('{done: 2'b01, y: 4'b0000, cout: 1'b1, zero: 1'b1});
    rq.push_back('{done: 2'b10, y: 4'b1111, cout: 1'b0, zero: 1'b0});
    fork
      do_req(0, 2'b11, 4'b0011, 4'b0011);
      do_req(1, 2'b01, 4'b1010, 4'b0101);
    join
    wait_idle();

    // Fairness: both re-request continuously for six operations
    gq.push_back(2'b01); gq.push_back(2'b10); gq.push_back(2'b01);
    gq.push_back(2'b10); gq.push_back(2'b01); gq.push_back(2'b10);
    rq.push_back('{done: 2'b01, y: 4'b0011, cout: 1'b0, zero: 1'b0});
    rq.push_back('{done: 2'b10, y: 4'b1101, cout: 1'b0, zero: 1'b0});
    rq.push_back('{done: 2'b01, y: 4'b0000, cout: 1'b0, zero: 1'b1});
    rq.push_back('{done: 2'b10, y: 4'b0000, cout: 1'b1, zero: 1'b1});
    rq.push_back('{done: 2'b01, y: 4'b0110, cout: 1'b0, zero: 1'b0});
    rq.push_back('{done: 2'b10, y: 4'b0101, cout: 1'b1, zero: 1'b0});
    fork
      begin
        do_req(0, 2'b10, 4'b0001, 4'b0010);
        do_req(0, 2'b01, 4'b0000, 4'b0000);
        do_req(0, 2'b00, 4'b1111, 4'b0110);
      end
      begin
        do_req(1, 2'b11, 4'b0010, 4'b0101);
        do_req(1, 2'b10, 4'b1000, 4'b1000);
        do_req(1, 2'b11, 4'b1001, 4'b0100);
      end
    join
    wait_idle();

    // Mid-operation reset: grant seen, reset during EXEC, no done expected
    gq.push_back(2'b10);
    do_req(1, 2'b00, 4'b1100, 4'b1010);
    rst = 1'b1;
    #2;
    check_reset_outputs("async");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort_done", {6'h0, bus.done}, 8'h00);
    gq.push_back(2'b10);
    rq.push_back('{done: 2'b10, y: 4'b1000, cout: 1'b0, zero: 1'b0});
    do_req(1, 2'b00, 4'b1100, 4'b1010);
    wait_idle();

    // Operand change after capture must not affect the operation
    gq.push_back(2'b01);
    rq.push_back('{done: 2'b01, y: 4'b0001, cout: 1'b0, zero: 1'b0});
    do_req(0, 2'b00, 4'b0101, 4'b0011);
    bus.a0 = 4'b1111;
    wait_idle();
    repeat (2) @(negedge clk);

    chk("queues_empty", 8'(gq.size() + rq.size()), 8'h00);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
